// File: rtl/uart_frame_parser_pkg.sv
// Shared types and helpers for the UART frame parser: FSM state encoding, the default
// start-of-frame marker and the frame-length width helper.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    StHunt = 3'd0,
    StLen  = 3'd1,
    StPay  = 3'd2,
    StChk  = 3'd3,
    StOut  = 3'd4
  } state_e;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  function automatic int unsigned len_w(input int unsigned max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Payload stream from the frame parser to the command decoder: valid/ready byte stream with a
// last marker and the length of the frame currently being drained.
interface uart_frame_parser_if #(
  parameter int unsigned MAX_LEN = 16
) ();
  import uart_frame_pkg::*;

  localparam int unsigned LEN_W = len_w(MAX_LEN);

  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [LEN_W-1:0] frame_len;

  modport master (
    output out_data,
    output out_valid,
    output out_last,
    output frame_len,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_last,
    input  frame_len,
    output out_ready
  );

endinterface

// File: rtl/uart_frame_parser_buf.sv
// Payload store for one frame: DEPTH x 8 register file, synchronous write, asynchronous read.
// Storage is deliberately not reset; contents are only read after a full frame is written.
module uart_frame_buf #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SOF, LEN, payload, checksum; good payloads are replayed
// on out_if. Inter-byte timeout is built only when UART_FRAME_TIMEOUT_EN is defined.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 16,
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1_250_000
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       rcv,
  input  logic [7:0]                 data,
  uart_frame_parser_if.master        out_if,
  output logic                       chk_err,
  output logic                       len_err,
  output logic                       ovr_err,
  output logic                       tmo_err
);

  localparam int unsigned LEN_W = len_w(MAX_LEN);
  localparam int unsigned AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("uart_frame_parser: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] wr_idx_q, wr_idx_d;
  logic [LEN_W-1:0] rd_idx_q, rd_idx_d;
  logic [7:0]       sum_q, sum_d;
  logic             chk_err_q, chk_err_d;
  logic             len_err_q, len_err_d;
  logic             ovr_err_q, ovr_err_d;
  logic             tmo_err_q, tmo_err_d;

  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             out_valid, out_last, xfer, len_bad, tmo_hit;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .we    (buf_we),
    .waddr (wr_idx_q[AW-1:0]),
    .wdata (data),
    .raddr (rd_idx_q[AW-1:0]),
    .rdata (buf_rdata)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             in_frame;

  // Counts idle cycles only while a frame is partially received.
  always_comb begin
    in_frame  = state_q inside {StLen, StPay, StChk};
    tmo_hit   = in_frame && !rcv && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
    tmo_cnt_d = (in_frame && !rcv && !tmo_hit) ? tmo_cnt_q + TMO_W'(1) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StHunt;
      len_q     <= '0;
      wr_idx_q  <= '0;
      rd_idx_q  <= '0;
      sum_q     <= '0;
      chk_err_q <= 1'b0;
      len_err_q <= 1'b0;
      ovr_err_q <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
      len_err_q <= len_err_d;
      ovr_err_q <= ovr_err_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    sum_d     = sum_q;
    buf_we    = 1'b0;
    chk_err_d = 1'b0;
    len_err_d = 1'b0;
    ovr_err_d = 1'b0;
    tmo_err_d = 1'b0;
    len_bad   = (data == 8'd0) || (32'(data) > MAX_LEN);

    unique case (state_q)
      StHunt: begin
        if (rcv && data == SOF_BYTE) state_d = StLen;
      end
      StLen: begin
        if (rcv) begin
          if (len_bad) begin
            len_err_d = 1'b1;
            state_d   = StHunt;
          end else begin
            len_d    = data[LEN_W-1:0];
            sum_d    = data;
            wr_idx_d = '0;
            state_d  = StPay;
          end
        end
      end
      StPay: begin
        if (rcv) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + data;
          wr_idx_d = wr_idx_q + LEN_W'(1);
          if (wr_idx_q == len_q - LEN_W'(1)) state_d = StChk;
        end
      end
      StChk: begin
        if (rcv) begin
          if (data == sum_q) begin
            rd_idx_d = '0;
            state_d  = StOut;
          end else begin
            chk_err_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StOut: begin
        // No queuing: a byte arriving while draining is lost.
        if (rcv) ovr_err_d = 1'b1;
        if (xfer) begin
          rd_idx_d = rd_idx_q + LEN_W'(1);
          if (out_last) state_d = StHunt;
        end
      end
      default: state_d = StHunt;
    endcase

    if (tmo_hit) begin
      tmo_err_d = 1'b1;
      state_d   = StHunt;
    end
  end

  always_comb begin
    out_valid = (state_q == StOut);
    out_last  = out_valid && (rd_idx_q == len_q - LEN_W'(1));
    xfer      = out_valid && out_if.out_ready;
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_last  = out_last;
  assign out_if.out_data  = out_valid ? buf_rdata : 8'd0;
  assign out_if.frame_len = out_valid ? len_q : '0;

  assign chk_err = chk_err_q;
  assign len_err = len_err_q;
  assign ovr_err = ovr_err_q;
  assign tmo_err = tmo_err_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames from the test plan plus a random
// frame stream checked against a frame-level reference model.
module tb_uart_frame_parser;

  localparam int unsigned MAX_LEN = 16;
  localparam int unsigned TMO     = 100;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rcv  = 1'b0;
  logic [7:0] data = 8'd0;
  logic       chk_err, len_err, ovr_err, tmo_err;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) out_if ();

  uart_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .rcv     (rcv),
    .data    (data),
    .out_if  (out_if),
    .chk_err (chk_err),
    .len_err (len_err),
    .ovr_err (ovr_err),
    .tmo_err (tmo_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ready_mode = 0;  // 0 always ready, 1 toggle, 2 random, 3 never ready
  int tmo_seen = 0;

  logic [7:0] got_data[$];
  bit         got_last[$];
  int         got_flen[$];
  int         got_cyc[$];
  int         stb_cyc[$];
  int         chk_cyc[$];
  int         len_cyc[$];
  int         ovr_cyc[$];
  int         tmo_cyc[$];

  logic [7:0] exp_pay[$];
  bit         exp_last[$];
  int         exp_flen[$];
  int         exp_len_idx[$];
  int         exp_chk_idx[$];

  bit         hold_pend = 1'b0;
  logic [7:0] hold_data;
  logic       hold_last;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       out_if.out_ready = 1'b1;
      1:       out_if.out_ready = ~out_if.out_ready;
      2:       out_if.out_ready = 1'($urandom_range(0, 1));
      default: out_if.out_ready = 1'b0;
    endcase
  end

  // Sample everything mid-cycle; also check that a stalled byte stays put.
  always @(negedge clk) begin
    if (rstn) begin
      if (rcv) stb_cyc.push_back(cyc);
      if (out_if.out_valid && out_if.out_ready) begin
        got_data.push_back(out_if.out_data);
        got_last.push_back(out_if.out_last);
        got_flen.push_back(int'(out_if.frame_len));
        got_cyc.push_back(cyc);
      end
      if (chk_err) chk_cyc.push_back(cyc);
      if (len_err) len_cyc.push_back(cyc);
      if (ovr_err) ovr_cyc.push_back(cyc);
      if (tmo_err) begin
        tmo_cyc.push_back(cyc);
        tmo_seen++;
      end
      if (hold_pend) begin
        total++;
        if (!out_if.out_valid || out_if.out_data !== hold_data || out_if.out_last !== hold_last)
        begin
          bad++;
          $display("FAIL hold_stable @%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc,
                   out_if.out_valid, out_if.out_data, out_if.out_last, hold_data, hold_last);
        end
      end
      hold_pend = out_if.out_valid && !out_if.out_ready;
      hold_data = out_if.out_data;
      hold_last = out_if.out_last;
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_raw(input logic [7:0] b);
    rcv  = 1'b1;
    data = b;
    tick();
    rcv  = 1'b0;
  endtask

  // Never start a byte while a frame is draining.
  task automatic send_byte(input logic [7:0] b);
    int g = 0;
    while (out_if.out_valid && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_wait: out_valid=%b after %0d cycles, want 0", out_if.out_valid, g);
    end
    send_raw(b);
  endtask

  task automatic drain();
    int g = 0;
    while (out_if.out_valid && g < 400) begin
      tick();
      g++;
    end
    if (g >= 400) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: out_valid=%b, want 0", out_if.out_valid);
    end
    idle(2);
  endtask

  task automatic clear_rec();
    got_data.delete(); got_last.delete(); got_flen.delete(); got_cyc.delete();
    stb_cyc.delete(); chk_cyc.delete(); len_cyc.delete(); ovr_cyc.delete(); tmo_cyc.delete();
  endtask

  // Frame-level reference: scan the byte list for SOF, then LEN / payload / CHK by index.
  function automatic void model_stream(input logic [7:0] b[$]);
    int i = 0;
    int l;
    logic [7:0] s;
    exp_pay.delete(); exp_last.delete(); exp_flen.delete();
    exp_len_idx.delete(); exp_chk_idx.delete();
    while (i < b.size()) begin
      if (b[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= b.size()) break;
      l = int'(b[i+1]);
      if (l == 0 || l > MAX_LEN) begin
        exp_len_idx.push_back(i + 1);
        i += 2;
        continue;
      end
      if (i + 2 + l >= b.size()) break;
      s = 8'(l);
      for (int k = 0; k < l; k++) s = s + b[i+2+k];
      if (b[i+2+l] == s) begin
        for (int k = 0; k < l; k++) begin
          exp_pay.push_back(b[i+2+k]);
          exp_last.push_back(k == l - 1);
          exp_flen.push_back(l);
        end
      end else begin
        exp_chk_idx.push_back(i + 2 + l);
      end
      i += 3 + l;
    end
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    ready_mode = 0;
    idle(3);
    total++;
    if ({out_if.out_valid, out_if.out_last, out_if.frame_len, out_if.out_data} !== '0) begin
      bad++;
      $display("FAIL reset_out: got v=%b l=%b len=%0d d=%h want all 0", out_if.out_valid,
               out_if.out_last, out_if.frame_len, out_if.out_data);
    end
    total++;
    if ({chk_err, len_err, ovr_err, tmo_err} !== 4'b0) begin
      bad++;
      $display("FAIL reset_err: got %b want 0000", {chk_err, len_err, ovr_err, tmo_err});
    end
    rstn = 1'b1;
    idle(2);
    total++;
    if ({out_if.out_valid, chk_err, len_err, ovr_err, tmo_err} !== 5'b0) begin
      bad++;
      $display("FAIL post_reset: got %b want 00000",
               {out_if.out_valid, chk_err, len_err, ovr_err, tmo_err});
    end
  endtask

  task automatic test_good_frame();
    logic [7:0] fr[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    logic [7:0] want[3] = '{8'h11, 8'h22, 8'h33};
    clear_rec();
    ready_mode = 0;
    foreach (fr[i]) send_byte(fr[i]);
    drain();
    total++;
    if (got_data.size() != 3) begin
      bad++;
      $display("FAIL good_count: got %0d want 3", got_data.size());
    end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      total++;
      if (got_data[k] !== want[k] || got_last[k] !== (k == 2) || got_flen[k] != 3 ||
          got_cyc[k] != stb_cyc[5] + 1 + k) begin
        bad++;
        $display("FAIL good_byte[%0d]: got d=%h l=%b len=%0d cyc=%0d want d=%h l=%b len=3 cyc=%0d",
                 k, got_data[k], got_last[k], got_flen[k], got_cyc[k], want[k], k == 2,
                 stb_cyc[5] + 1 + k);
      end
    end
    total++;
    if (chk_cyc.size() + len_cyc.size() + ovr_cyc.size() != 0) begin
      bad++;
      $display("FAIL good_errs: got chk=%0d len=%0d ovr=%0d want 0", chk_cyc.size(),
               len_cyc.size(), ovr_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] fr[$] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    logic [7:0] want[3] = '{8'h11, 8'h22, 8'h33};
    clear_rec();
    ready_mode = 1;
    foreach (fr[i]) send_byte(fr[i]);
    drain();
    ready_mode = 0;
    total++;
    if (got_data.size() != 3) begin
      bad++;
      $display("FAIL bp_count: got %0d want 3", got_data.size());
    end
    for (int k = 0; k < 3 && k < got_data.size(); k++) begin
      total++;
      if (got_data[k] !== want[k] || got_last[k] !== (k == 2)) begin
        bad++;
        $display("FAIL bp_byte[%0d]: got d=%h l=%b want d=%h l=%b", k, got_data[k],
                 got_last[k], want[k], k == 2);
      end
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] fr[$] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h00, 8'hA5, 8'h01, 8'hFF, 8'h00};
    clear_rec();
    ready_mode = 0;
    foreach (fr[i]) send_byte(fr[i]);
    drain();
    total++;
    if (chk_cyc.size() != 1 || chk_cyc[0] != stb_cyc[4] + 1) begin
      bad++;
      $display("FAIL chk_pulse: got n=%0d cyc=%0d want n=1 cyc=%0d", chk_cyc.size(),
               (chk_cyc.size() > 0) ? chk_cyc[0] : -1, stb_cyc[4] + 1);
    end
    total++;
    if (got_data.size() != 1 || got_data[0] !== 8'hFF || got_last[0] !== 1'b1 ||
        got_flen[0] != 1 || got_cyc[0] != stb_cyc[8] + 1) begin
      bad++;
      $display("FAIL chk_next_frame: got n=%0d d=%h want n=1 d=ff last=1 len=1",
               got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'h00);
    end
  endtask

  task automatic test_len_err();
    logic [7:0] fr[$] = '{8'h00, 8'hFF, 8'h12, 8'hA5, 8'h00, 8'hA5, 8'h11,
                          8'hA5, 8'h02, 8'hA5, 8'h5A, 8'h01};
    clear_rec();
    ready_mode = 0;
    foreach (fr[i]) send_byte(fr[i]);
    drain();
    total++;
    if (len_cyc.size() != 2) begin
      bad++;
      $display("FAIL len_count: got %0d want 2", len_cyc.size());
    end else begin
      total++;
      if (len_cyc[0] != stb_cyc[4] + 1 || len_cyc[1] != stb_cyc[6] + 1) begin
        bad++;
        $display("FAIL len_cycles: got %0d,%0d want %0d,%0d", len_cyc[0], len_cyc[1],
                 stb_cyc[4] + 1, stb_cyc[6] + 1);
      end
    end
    total++;
    if (got_data.size() != 2 || got_data[0] !== 8'hA5 || got_data[1] !== 8'h5A ||
        chk_cyc.size() != 0) begin
      bad++;
      $display("FAIL len_next_frame: got n=%0d chk=%0d want n=2 (a5 5a) chk=0",
               got_data.size(), chk_cyc.size());
    end
  endtask

  task automatic test_overrun();
    logic [7:0] fr[$] = '{8'hA5, 8'h01, 8'h77, 8'h78};
    clear_rec();
    ready_mode = 3;
    foreach (fr[i]) send_byte(fr[i]);
    idle(1);
    send_raw(8'h55);
    idle(1);
    total++;
    if (ovr_cyc.size() != 1 || ovr_cyc[0] != stb_cyc[4] + 1) begin
      bad++;
      $display("FAIL ovr_pulse: got n=%0d want n=1 at cyc %0d", ovr_cyc.size(), stb_cyc[4] + 1);
    end
    total++;
    if (out_if.out_valid !== 1'b1 || out_if.out_data !== 8'h77 || out_if.out_last !== 1'b1 ||
        got_data.size() != 0) begin
      bad++;
      $display("FAIL ovr_hold: got v=%b d=%h l=%b n=%0d want v=1 d=77 l=1 n=0",
               out_if.out_valid, out_if.out_data, out_if.out_last, got_data.size());
    end
    // Final transfer and a new strobe land on the same cycle.
    ready_mode = 0;
    send_raw(8'h66);
    idle(1);
    total++;
    if (ovr_cyc.size() != 2 || got_data.size() != 1 || got_data[0] !== 8'h77 ||
        got_cyc[0] != stb_cyc[5] || out_if.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL ovr_last_xfer: got ovr=%0d n=%0d v=%b want ovr=2 n=1 (77) v=0",
               ovr_cyc.size(), got_data.size(), out_if.out_valid);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[$] = '{8'hA5, 8'h04, 8'h01, 8'h02};
    logic [7:0] gf[$] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
    ready_mode = 0;
    foreach (fr[i]) send_byte(fr[i]);
    rstn = 1'b0;
    tick();
    total++;
    if ({out_if.out_valid, out_if.out_last, out_if.frame_len, out_if.out_data,
         chk_err, len_err, ovr_err, tmo_err} !== '0) begin
      bad++;
      $display("FAIL mid_reset_out: got v=%b l=%b len=%0d d=%h errs=%b want all 0",
               out_if.out_valid, out_if.out_last, out_if.frame_len, out_if.out_data,
               {chk_err, len_err, ovr_err, tmo_err});
    end
    tick();
    rstn = 1'b1;
    tick();
    clear_rec();
    foreach (gf[i]) send_byte(gf[i]);
    drain();
    total++;
    if (got_data.size() != 2 || got_data[0] !== 8'h10 || got_data[1] !== 8'h20 ||
        got_last[1] !== 1'b1 || chk_cyc.size() + len_cyc.size() != 0) begin
      bad++;
      $display("FAIL mid_reset_next: got n=%0d chk=%0d len=%0d want n=2 (10 20) no errors",
               got_data.size(), chk_cyc.size(), len_cyc.size());
    end
  endtask

  task automatic test_random();
    logic [7:0] s[$];
    logic [7:0] x, sum;
    int ng, kind, l;
    for (int f = 0; f < 30; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        x = 8'($urandom_range(0, 255));
        if (x == 8'hA5) x = 8'h00;
        s.push_back(x);
      end
      kind = $urandom_range(0, 9);
      s.push_back(8'hA5);
      if (kind == 0) begin
        l = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
        s.push_back(8'(l));
      end else begin
        l = $urandom_range(1, MAX_LEN);
        s.push_back(8'(l));
        sum = 8'(l);
        for (int k = 0; k < l; k++) begin
          x = 8'($urandom_range(0, 255));
          s.push_back(x);
          sum = sum + x;
        end
        if (kind == 1) sum = sum ^ 8'($urandom_range(1, 255));
        s.push_back(sum);
      end
    end
    model_stream(s);
    clear_rec();
    ready_mode = 2;
    foreach (s[i]) begin
      send_byte(s[i]);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    drain();
    ready_mode = 0;
    total++;
    if (got_data.size() != exp_pay.size()) begin
      bad++;
      $display("FAIL rnd_count: got %0d want %0d", got_data.size(), exp_pay.size());
    end
    for (int k = 0; k < got_data.size() && k < exp_pay.size(); k++) begin
      total++;
      if (got_data[k] !== exp_pay[k] || got_last[k] !== exp_last[k] ||
          got_flen[k] != exp_flen[k]) begin
        bad++;
        $display("FAIL rnd_byte[%0d]: got d=%h l=%b len=%0d want d=%h l=%b len=%0d", k,
                 got_data[k], got_last[k], got_flen[k], exp_pay[k], exp_last[k], exp_flen[k]);
      end
    end
    total++;
    if (len_cyc.size() != exp_len_idx.size() || chk_cyc.size() != exp_chk_idx.size() ||
        ovr_cyc.size() != 0) begin
      bad++;
      $display("FAIL rnd_err_count: got len=%0d chk=%0d ovr=%0d want len=%0d chk=%0d ovr=0",
               len_cyc.size(), chk_cyc.size(), ovr_cyc.size(), exp_len_idx.size(),
               exp_chk_idx.size());
    end
    for (int j = 0; j < len_cyc.size() && j < exp_len_idx.size(); j++) begin
      total++;
      if (len_cyc[j] != stb_cyc[exp_len_idx[j]] + 1) begin
        bad++;
        $display("FAIL rnd_len_cyc[%0d]: got %0d want %0d", j, len_cyc[j],
                 stb_cyc[exp_len_idx[j]] + 1);
      end
    end
    for (int j = 0; j < chk_cyc.size() && j < exp_chk_idx.size(); j++) begin
      total++;
      if (chk_cyc[j] != stb_cyc[exp_chk_idx[j]] + 1) begin
        bad++;
        $display("FAIL rnd_chk_cyc[%0d]: got %0d want %0d", j, chk_cyc[j],
                 stb_cyc[exp_chk_idx[j]] + 1);
      end
    end
  endtask

  task automatic test_timeout();
`ifdef UART_FRAME_TIMEOUT_EN
    logic [7:0] fr[$] = '{8'hA5, 8'h02, 8'h10};
    logic [7:0] gf[$] = '{8'hA5, 8'h01, 8'h33, 8'h34};
    clear_rec();
    ready_mode = 0;
    foreach (fr[i]) send_byte(fr[i]);
    idle(TMO + 10);
    total++;
    if (tmo_cyc.size() != 1 || tmo_cyc[0] != stb_cyc[2] + int'(TMO)) begin
      bad++;
      $display("FAIL tmo_pulse: got n=%0d cyc=%0d want n=1 cyc=%0d", tmo_cyc.size(),
               (tmo_cyc.size() > 0) ? tmo_cyc[0] : -1, stb_cyc[2] + int'(TMO));
    end
    foreach (gf[i]) send_byte(gf[i]);
    drain();
    total++;
    if (got_data.size() != 1 || got_data[0] !== 8'h33 || chk_cyc.size() != 0) begin
      bad++;
      $display("FAIL tmo_next_frame: got n=%0d chk=%0d want n=1 (33) chk=0", got_data.size(),
               chk_cyc.size());
    end
`else
    total++;
    if (tmo_seen != 0 || tmo_err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_tied: got pulses=%0d tmo_err=%b want 0", tmo_seen, tmo_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_backpressure();
    test_bad_chk();
    test_len_err();
    test_overrun();
    test_reset_mid();
    test_random();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
